transform_scheduler: RTL

Sequencing controller for the 4x4 transform-coding datapath (forward transform → quantiser → inverse quantiser → inverse transform). It accepts residual blocks from prediction one at a time, grouped into macroblocks of 16 blocks. It drives the shared `enable` of all four datapath stages and derives `QP_BY_6`/`QP_MOD_6` once per macroblock. It drains the pipeline before any QP change, so no in-flight block is quantised with a mixed QP, and it tags each reconstructed block with its index within the macroblock.

---
 rtl/transform_scheduler.sv | 90 +++++++++
 1 files changed

// File: rtl/transform_scheduler.sv
// transform_scheduler: sequences the 4x4 transform pipeline, splits QP per macroblock and tags output blocks
module transform_scheduler #(
  parameter int PIPE_LATENCY = 4,
  parameter int BLOCKS_PER_MB = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mb_start,
  input  logic [5:0] QP,
  output logic       pipe_enable,
  output logic [3:0] QP_BY_6,
  output logic [2:0] QP_MOD_6,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_blk_idx,
  output logic       out_mb_last,
  output logic       busy,
  output logic       qp_err,
  output logic       mb_err
);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, CALC = 2'd2, RUN = 2'd3;
  logic [1:0] state;
  logic [4:0] blk_cnt;
  logic [5:0] qp_rem, qp_clamp;
  logic [3:0] q;
  logic [PIPE_LATENCY-1:0] vld, last_sr;
  logic [4*PIPE_LATENCY-1:0] idx_sr;
  logic full, new_mb, take_qp, acc;
  assign full = blk_cnt == 5'(BLOCKS_PER_MB);
  assign new_mb = in_valid & mb_start;
  assign take_qp = new_mb & ((state == IDLE) | ((state == RUN) & full));
  assign qp_clamp = QP > 6'd51 ? 6'd51 : QP;
  assign out_valid = vld[PIPE_LATENCY-1];
  assign out_blk_idx = idx_sr[4*PIPE_LATENCY-1 -: 4];
  assign out_mb_last = last_sr[PIPE_LATENCY-1];
  assign pipe_enable = ~reset & ~(out_valid & ~out_ready);
  // the first block of a macroblock must carry mb_start, so a stray block cannot open one
  assign in_ready = (state == RUN) & pipe_enable & (blk_cnt < 5'(BLOCKS_PER_MB)) & ((blk_cnt != 5'd0) | mb_start);
  assign acc = in_valid & in_ready;
  assign busy = (state != IDLE) | (|vld);
  // in-flight valid/tag shadow of the datapath; bubbles carry zero tags so idle outputs read 0
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      last_sr <= '0;
      idx_sr <= '0;
    end else if (pipe_enable) begin
      vld <= PIPE_LATENCY'({vld, acc});
      last_sr <= PIPE_LATENCY'({last_sr, acc & (blk_cnt == 5'(BLOCKS_PER_MB - 1))});
      idx_sr <= (4*PIPE_LATENCY)'({idx_sr, acc ? blk_cnt[3:0] : 4'd0});
    end
  end
  // control FSM: QP divides by repeated subtraction in CALC; QP outputs only move on CALC exit
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      blk_cnt <= '0;
      qp_rem <= '0;
      q <= '0;
      QP_BY_6 <= '0;
      QP_MOD_6 <= '0;
      qp_err <= 1'b0;
      mb_err <= 1'b0;
    end else begin
      qp_err <= take_qp & (QP > 6'd51);
      mb_err <= acc & mb_start & (blk_cnt != 5'd0);
      if (take_qp) begin
        qp_rem <= qp_clamp;
        q <= '0;
      end
      if (acc) blk_cnt <= blk_cnt + 5'd1;
      if ((state == IDLE) & new_mb) state <= CALC;
      else if ((state == RUN) & full) state <= new_mb ? DRAIN : (~|vld ? IDLE : RUN);
      else if ((state == DRAIN) & ~|vld) state <= CALC;
      else if (state == CALC) begin
        if (qp_rem >= 6'd6) begin
          qp_rem <= qp_rem - 6'd6;
          q <= q + 4'd1;
        end else begin
          QP_BY_6 <= q;
          QP_MOD_6 <= qp_rem[2:0];
          blk_cnt <= '0;
          state <= RUN;
        end
      end
    end
  end
endmodule
